// File: rtl/seq_divider_4by2_if.sv
// Operand/result bundle for the 4-by-2 sequential divider.
// The master drives start and operands; the slave returns results and status.
interface seq_divider_4by2_if;
  logic       start;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic [3:0] quotient;
  logic [1:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider_4by2.sv
// Restoring 4-by-2 unsigned divider, one quotient bit per clock; done 4 cycles after capture (1 for divisor 0).
// No backpressure: start is ignored while busy, and results hold until the next done.
module seq_divider_4by2 (
  input  logic                     clk,
  input  logic                     rst_n,
  seq_divider_4by2_if.slave        bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0] state;
  logic [3:0] dvd_q;
  logic [1:0] dsr_q;
  logic [2:0] prem_q;
  logic [3:0] qacc_q;
  logic [1:0] cnt_q;
  logic [3:0] quotient_q;
  logic [1:0] remainder_q;
  logic       busy_q;
  logic       done_q;
  logic       dbz_q;

  logic       accept;
  logic       dvd_bit;
  logic [3:0] trial;
  logic       fits;
  logic [2:0] nxt_prem;
  logic [3:0] nxt_qacc;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // Trial subtraction of the shifted partial remainder; a clear sign bit means the divisor fits.
  always_comb begin
    dvd_bit  = dvd_q[cnt_q];
    trial    = {prem_q, dvd_bit} - {2'b00, dsr_q};
    fits     = ~trial[3];
    nxt_prem = fits ? trial[2:0] : {prem_q[1:0], dvd_bit};
    nxt_qacc = {qacc_q[2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_q       <= 4'd0;
      dsr_q       <= 2'd0;
      prem_q      <= 3'd0;
      qacc_q      <= 4'd0;
      cnt_q       <= 2'd0;
      quotient_q  <= 4'd0;
      remainder_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            dvd_q  <= bus.dividend;
            dsr_q  <= bus.divisor;
            prem_q <= 3'd0;
            qacc_q <= 4'd0;
            cnt_q  <= 2'd3;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          if (dsr_q == 2'd0) begin
            quotient_q  <= 4'hF;
            remainder_q <= 2'b00;
            dbz_q       <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= DONE;
          end else begin
            prem_q <= nxt_prem;
            qacc_q <= nxt_qacc;
            cnt_q  <= cnt_q - 2'd1;
            // Last bit: results go straight to the output registers, never intermediates.
            if (cnt_q == 2'd0) begin
              quotient_q  <= nxt_qacc;
              remainder_q <= nxt_prem[1:0];
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state       <= DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_4by2.sv
// Directed bench for seq_divider_4by2 with hand-computed expectations.
module tb_seq_divider_4by2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_4by2_if bus();

  seq_divider_4by2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and wait (bounded) for done; then check results and the single-cycle pulse.
  task automatic run_op(input logic [3:0] a, input logic [1:0] b,
                        input logic [3:0] eq, input logic [1:0] er,
                        input logic edz, input int elat, input string tag);
    int lat;
    int busy_gap;
    lat      = 0;
    busy_gap = 0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
      if (!bus.busy) busy_gap = 1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
    chk({tag, "_quot"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edz));
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    step();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          done_cnt;
    logic [3:0]  eq;
    logic [1:0]  er;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 4'd5;
    bus.divisor  = 2'd1;

    // Reset holds everything at zero even with start asserted.
    repeat (3) step();
    chk("reset_outputs", 32'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    step();
    chk("post_reset_idle", 32'({bus.busy, bus.done}), 32'd0);

    // Basic divide 9/2.
    run_op(4'd9, 2'd2, 4'd4, 2'd1, 1'b0, 4, "div_9_2");

    // Divide by zero then recovery with 6/3.
    run_op(4'd6, 2'd0, 4'd15, 2'd0, 1'b1, 1, "div_6_0");
    chk("dbz_held", 32'(bus.div_by_zero), 32'd1);
    chk("dbz_quot_held", 32'(bus.quotient), 32'd15);
    run_op(4'd6, 2'd3, 4'd2, 2'd0, 1'b0, 4, "div_6_3");

    // Start during busy is ignored: 15/3 with 7/1 offered at E2.
    bus.dividend = 4'd15;
    bus.divisor  = 2'd3;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    step();
    bus.dividend = 4'd7;
    bus.divisor  = 2'd1;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    done_cnt     = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done) begin
        done_cnt++;
        chk("ign_quot", 32'(bus.quotient), 32'd5);
        chk("ign_rem", 32'(bus.remainder), 32'd0);
        chk("ign_done_at_e4", 32'(i), 32'd1);
      end
    end
    chk("ign_done_count", 32'(done_cnt), 32'd1);

    // Back-to-back: 8/3 then 3/1 captured on the DONE edge.
    bus.dividend = 4'd8;
    bus.divisor  = 2'd3;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    repeat (4) step();
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    chk("b2b_first_quot", 32'(bus.quotient), 32'd2);
    chk("b2b_first_rem", 32'(bus.remainder), 32'd2);
    bus.dividend = 4'd3;
    bus.divisor  = 2'd1;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    chk("b2b_capture_busy", 32'(bus.busy), 32'd1);
    chk("b2b_capture_done", 32'(bus.done), 32'd0);
    repeat (3) begin
      step();
      chk("b2b_hold_result", 32'({bus.quotient, bus.remainder, bus.done}), 32'({4'd2, 2'd2, 1'b0}));
    end
    step();
    chk("b2b_second_done", 32'(bus.done), 32'd1);
    chk("b2b_second_quot", 32'(bus.quotient), 32'd3);
    chk("b2b_second_rem", 32'(bus.remainder), 32'd0);
    step();

    // Reset at E2 of 12/2 aborts with no later done.
    bus.dividend = 4'd12;
    bus.divisor  = 2'd2;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}), 32'd0);
    #1;
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done || bus.busy) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Exhaustive sweep over all operand pairs.
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        if (s == 0) begin
          eq = 4'hF;
          er = 2'd0;
        end else begin
          eq = 4'(d / s);
          er = 2'(d % s);
        end
        run_op(4'(d), 2'(s), eq, er, (s == 0), (s == 0) ? 1 : 4,
               $sformatf("sweep_%0d_%0d", d, s));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_4by2.md
SEQ_DIVIDER_4BY2 -- requirements
Module: seq_divider_4by2

Interface
REQ-001 SHALL provide these ports: clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL provide these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide these ports: start, input, 1, request pulse to begin a division.
REQ-004 SHALL provide these ports: dividend, input, 4, unsigned dividend (product range of the 2x2 multiplier).
REQ-005 SHALL provide these ports: divisor, input, 2, unsigned divisor.
REQ-006 SHALL provide these ports: quotient, output, 4, unsigned quotient, registered.
REQ-007 SHALL provide these ports: remainder, output, 2, unsigned remainder, registered.
REQ-008 SHALL provide these ports: busy, output, 1, high while an operation is in progress.
REQ-009 SHALL provide these ports: done, output, 1, one-cycle pulse marking valid results.
REQ-010 SHALL provide these ports: div_by_zero, output, 1, high with done when divisor was 0; held until the next accepted start.
REQ-011 Clocking SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL capture dividend and divisor into internal registers.
- That edge is E0.
- The FSM enters RUN with an iteration counter of 3.
- busy=1 from E0.
REQ-014 While busy=1, start SHALL be ignored; dividend and divisor SHALL NOT be resampled.
REQ-015 RUN SHALL perform restoring division MSB-first, one quotient bit per clock, at edges E1..E4.
- The partial remainder is 3 bits wide and is shifted left with the next dividend bit.
- If partial remainder >= divisor: subtract divisor and set the quotient bit to 1.
- Otherwise: keep the partial remainder and set the quotient bit to 0.
REQ-016 At E4 the FSM SHALL enter DONE.
- Final quotient and the low 2 bits of the partial remainder are loaded onto the outputs.
- busy=0 and done=1 from E4 to E5.
- Total latency is 4 cycles from the capture edge.
REQ-017 done SHALL be high for exactly one cycle per accepted start.
- DONE returns to IDLE at the next edge unless start=1, in which case a new operation is captured (back-to-back).
REQ-018 quotient and remainder SHALL hold their last result until the next DONE entry; they SHALL NOT show intermediate values during RUN.
REQ-019 Invariant: quotient*divisor + remainder = dividend and remainder < divisor, for every divisor in 1..3.
REQ-020 Divisor 0 captured at E0 SHALL skip RUN and enter DONE at E1.
- done=1 and div_by_zero=1 during that cycle.
- quotient=4'hF, remainder=2'b00.
- div_by_zero stays high until the next accepted start clears it.
REQ-021 When start and the DONE-to-IDLE transition coincide, start SHALL take priority: the new capture occurs and done is still high for that one cycle.

Reset
REQ-022 rst_n=0 SHALL asynchronously force the following, regardless of clk:
- FSM state to IDLE;
- quotient=0, remainder=0;
- busy=0, done=0, div_by_zero=0;
- all internal registers to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow the reset release.
REQ-024 After rst_n rises, the first start SHALL be accepted no earlier than the first rising edge at which rst_n is sampled high.

Verification
REQ-025 Basic divide: dividend=9, divisor=2, start pulse.
- busy=1 for 4 cycles.
- done pulses at E4.
- quotient=4, remainder=1.
REQ-026 Exhaustive: all 64 dividend/divisor pairs, each run to done.
- For divisor 1..3, quotient and remainder match integer division.
- For divisor 0, the response follows REQ-020.
REQ-027 Divide by zero: dividend=6, divisor=0.
- done and div_by_zero high at E1.
- quotient=15, remainder=0.
- A following 6/3 gives quotient=2, remainder=0, div_by_zero=0.
REQ-028 Ignored start: start=1 again at E2 of a 15/3 operation with different operands (dividend=7, divisor=1).
- The result is still quotient=5, remainder=0.
- Exactly one done pulse.
REQ-029 Back-to-back: start held during DONE of 8/3.
- quotient=2, remainder=2 is presented.
- The next operation 3/1 is captured on the same edge.
- quotient=3, remainder=0 arrives 4 cycles later.
REQ-030 Reset mid-operation: rst_n pulsed low at E2 of 12/2.
- All outputs are 0 immediately.
- No done pulse appears in the following 8 cycles without a new start.
